gb_cart_bus_sched: RTL

- Sequences the physical Game Boy cartridge bus (cart clock, /RD, /WR, /CS, 16-bit address, 8-bit bidirectional data) in fixed 4-phase bus cycles.
- Shares the bus between the GB CPU pass-through and a host requester, such as the bridge engine that dumps camera SRAM images.
- Sits between the CPU-side cart signals and the cart_tran_bank* pin drivers.
- CPU has priority. A starvation counter requests a CPU hold so the host is guaranteed progress.

---
 rtl/gb_cart_bus_sched_if.sv | 56 +++++
 rtl/gb_cart_bus_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gb_cart_bus_sched_if.sv
// Bus interface for gb_cart_bus_sched: CPU pass-through side, host requester
// side and cartridge pin side grouped in one bundle. The scheduler uses the
// slave modport and the surrounding system uses the master modport.
interface gb_cart_bus_sched_if;
    logic        ce_bus;

    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;

    logic        host_req;
    logic        host_we;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        host_err;

    logic        cpu_hold;
    logic        busy;

    logic        cart_clk;
    logic        cart_nrd;
    logic        cart_nwr;
    logic        cart_ncs;
    logic [15:0] cart_addr;
    logic [7:0]  cart_dout;
    logic [7:0]  cart_din;
    logic        cart_data_dir;

    modport slave (
        input  ce_bus,
        input  cpu_rd, cpu_wr, cpu_addr, cpu_di,
        output cpu_do,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata, host_err,
        output cpu_hold, busy,
        output cart_clk, cart_nrd, cart_nwr, cart_ncs, cart_addr, cart_dout,
        input  cart_din,
        output cart_data_dir
    );

    modport master (
        output ce_bus,
        output cpu_rd, cpu_wr, cpu_addr, cpu_di,
        input  cpu_do,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata, host_err,
        input  cpu_hold, busy,
        input  cart_clk, cart_nrd, cart_nwr, cart_ncs, cart_addr, cart_dout,
        output cart_din,
        input  cart_data_dir
    );
endinterface

// File: rtl/gb_cart_bus_sched.sv
// Game Boy cartridge bus scheduler.
// Runs fixed 4-phase cartridge bus cycles (phase advances on ce_bus) and
// shares them between the CPU pass-through and a host requester. The CPU wins
// arbitration; a starvation counter raises cpu_hold after STARVE_LIMIT lost
// cycles so the host always makes progress.
// Optional feature macro: GB_CART_HOST_WRITE_EN. When defined, host writes run
// a normal write cycle; when undefined, a host write is answered with
// host_ack + host_err and never touches the cartridge.
module gb_cart_bus_sched #(
    parameter int unsigned STARVE_LIMIT = 8   // legal range 1..255
) (
    input  logic                clk_sys,
    input  logic                reset,
    gb_cart_bus_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

    logic [1:0]  phase_q,      phase_d;
    owner_e      owner_q,      owner_d;
    logic        we_q,         we_d;          // current cycle is a write
    logic        nop_q,        nop_d;         // granted host write squashed to no bus activity
    logic [15:0] addr_q,       addr_d;
    logic [7:0]  dout_q,       dout_d;
    logic [7:0]  cpu_do_q,     cpu_do_d;
    logic [7:0]  host_rdata_q, host_rdata_d;
    logic        host_ack_q,   host_ack_d;
    logic        host_err_q,   host_err_d;
    logic        cpu_hold_q,   cpu_hold_d;
    logic [7:0]  starve_q,     starve_d;

    logic boundary;      // ce_bus ending phase 3: arbitration point
    logic capture;       // ce_bus ending phase 2: read data sample point
    logic host_pending;  // host request that is not the one currently being served
    logic cpu_wants;
    logic active;        // current cycle drives strobes

    // State register: all scheduler state, cleared asynchronously.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            phase_q      <= 2'd0;
            owner_q      <= OWN_NONE;
            we_q         <= 1'b0;
            nop_q        <= 1'b0;
            addr_q       <= 16'h0000;
            dout_q       <= 8'h00;
            cpu_do_q     <= 8'hFF;
            host_rdata_q <= 8'h00;
            host_ack_q   <= 1'b0;
            host_err_q   <= 1'b0;
            cpu_hold_q   <= 1'b0;
            starve_q     <= 8'h00;
        end else begin
            phase_q      <= phase_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            nop_q        <= nop_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            cpu_do_q     <= cpu_do_d;
            host_rdata_q <= host_rdata_d;
            host_ack_q   <= host_ack_d;
            host_err_q   <= host_err_d;
            cpu_hold_q   <= cpu_hold_d;
            starve_q     <= starve_d;
        end
    end

    // Next state: phase advance, read capture, arbitration and starvation.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned and no latch is inferred.
        phase_d      = phase_q;
        owner_d      = owner_q;
        we_d         = we_q;
        nop_d        = nop_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        cpu_do_d     = cpu_do_q;
        host_rdata_d = host_rdata_q;
        host_ack_d   = 1'b0;
        host_err_d   = 1'b0;
        cpu_hold_d   = cpu_hold_q;
        starve_d     = starve_q;

        boundary     = bus.ce_bus && (phase_q == 2'd3);
        capture      = bus.ce_bus && (phase_q == 2'd2);
        // The request being completed at this boundary is still high until the
        // host sees its ack, so it must not win the next cycle as well.
        host_pending = bus.host_req && (owner_q != OWN_HOST);
        cpu_wants    = (bus.cpu_rd || bus.cpu_wr) && !cpu_hold_q;

        if (bus.ce_bus) begin
            phase_d = phase_q + 2'd1;
        end

        if (capture && !we_q && !nop_q) begin
            if (owner_q == OWN_CPU) begin
                cpu_do_d = bus.cart_din;
            end else if (owner_q == OWN_HOST) begin
                host_rdata_d = bus.cart_din;
            end
        end

        // The hold is released on the clock after the host ack.
        if (host_ack_q) begin
            cpu_hold_d = 1'b0;
        end

        if (boundary) begin
            if (owner_q == OWN_HOST) begin
                host_ack_d = 1'b1;
                host_err_d = nop_q;
            end

            if (cpu_hold_q && host_pending) begin
                owner_d = OWN_HOST;
            end else if (cpu_wants) begin
                owner_d = OWN_CPU;
            end else if (host_pending) begin
                owner_d = OWN_HOST;
            end else begin
                owner_d = OWN_NONE;
            end

            case (owner_d)
                OWN_CPU: begin
                    we_d   = bus.cpu_wr;
                    nop_d  = 1'b0;
                    addr_d = bus.cpu_addr;
                    dout_d = bus.cpu_di;
                    if (host_pending && (starve_q != 8'hFF)) begin
                        starve_d = starve_q + 8'd1;
                    end
                end
                OWN_HOST: begin
                    we_d   = bus.host_we;
`ifdef GB_CART_HOST_WRITE_EN
                    nop_d  = 1'b0;
`else
                    nop_d  = bus.host_we;
`endif
                    addr_d = bus.host_addr;
                    dout_d = bus.host_wdata;
                    starve_d = 8'h00;
                end
                default: begin
                    we_d  = 1'b0;
                    nop_d = 1'b0;
                end
            endcase

            if (32'(starve_d) >= STARVE_LIMIT) begin
                cpu_hold_d = 1'b1;
            end
        end
    end

    // Outputs: cartridge strobes decoded from phase, owner and direction.
    always_comb begin
        active            = (owner_q != OWN_NONE) && !nop_q;
        bus.cart_clk      = ~phase_q[1];
        bus.cart_nrd      = ~(active && !we_q);
        bus.cart_nwr      = ~(active && we_q && ((phase_q == 2'd1) || (phase_q == 2'd2)));
        bus.cart_data_dir = active && we_q;
        bus.cart_ncs      = ~(active && (phase_q != 2'd0) && (addr_q[15:13] == 3'b101));
        bus.cart_addr     = addr_q;
        bus.cart_dout     = dout_q;
        bus.busy          = (owner_q != OWN_NONE);
        bus.cpu_do        = cpu_do_q;
        bus.host_rdata    = host_rdata_q;
        bus.host_ack      = host_ack_q;
        bus.host_err      = host_err_q;
        bus.cpu_hold      = cpu_hold_q;
    end

endmodule
